// File: rtl/motor_pwm_core.sv
// motor_pwm_core: turns MotorDriver register values into H-bridge PWM, direction, brake and dead-time drive.
// Latency: 1 ACLK from counter/state to out_a/out_b/period_tick; period/duty/dir/dead-time shadows update at period ends.
// Backpressure: none, registers are sampled freely. Define MOTOR_PWM_DUTY_RAMP_EN to ramp duty toward its target.
module motor_pwm_core #(
  parameter int C_CNT_WIDTH = 16,
  parameter int C_DT_WIDTH  = 8
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] slv_reg0,
  input  logic [31:0] slv_reg1,
  input  logic [31:0] slv_reg2,
  input  logic [31:0] slv_reg3,
  output logic        out_a,
  output logic        out_b,
  output logic        period_tick,
  output logic [1:0]  state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;
  localparam logic [1:0] ST_BRAKE = 2'd3;

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [C_DT_WIDTH-1:0]  DT_ONE  = 1;

  // Control fields of the control register.
  logic en, dir, brk;
  assign en  = slv_reg0[0];
  assign dir = slv_reg0[1];
  assign brk = slv_reg0[2];

  // Register bits outside the fields used here are deliberately ignored.
  logic unused_reg_bits;
  assign unused_reg_bits = ^{slv_reg0, slv_reg1, slv_reg2, slv_reg3};

  logic [1:0]             state_q, state_d;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [C_DT_WIDTH-1:0]  dt_cnt_q, dt_cnt_d;
  logic [C_CNT_WIDTH-1:0] period_sh_q, period_sh_d;
  logic [C_CNT_WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic                   dir_sh_q, dir_sh_d;
  logic [C_DT_WIDTH-1:0]  dt_sh_q, dt_sh_d;
  logic                   out_a_q, out_a_d;
  logic                   out_b_q, out_b_d;
  logic                   tick_q, tick_d;

  logic period_run;
  logic wrap;
  logic load_sh;
  logic pwm;

`ifdef MOTOR_PWM_DUTY_RAMP_EN
  // Move cur toward tgt by at most step counts; step 0 jumps straight to tgt.
  function automatic logic [C_CNT_WIDTH-1:0] ramp_toward(
    input logic [C_CNT_WIDTH-1:0] cur,
    input logic [C_CNT_WIDTH-1:0] tgt,
    input logic [15:0]            step
  );
    logic [31:0]            step_w;
    logic [31:0]            diff_w;
    logic [C_CNT_WIDTH-1:0] diff;
    logic [C_CNT_WIDTH-1:0] step_c;
    step_w = {16'd0, step};
    step_c = step_w[C_CNT_WIDTH-1:0];
    diff   = (tgt > cur) ? (tgt - cur) : (cur - tgt);
    diff_w = '0;
    diff_w[C_CNT_WIDTH-1:0] = diff;
    if ((step == 16'd0) || (diff_w <= step_w)) begin
      return tgt;
    end else if (tgt > cur) begin
      return cur + step_c;
    end else begin
      return cur - step_c;
    end
  endfunction
`endif

  // A zero period means stopped: no counting, no tick, and shadows keep tracking the registers.
  assign period_run = (period_sh_q != '0);
  assign wrap       = (state_q == ST_RUN) && period_run && (cnt_q == period_sh_q - CNT_ONE);
  assign load_sh    = (state_q != ST_RUN) || !period_run || wrap;
  assign pwm        = (state_q == ST_RUN) && period_run && (cnt_q < duty_sh_q);

  // Next-state logic: enable low wins over brake, brake wins over a direction change.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = brk ? ST_BRAKE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (brk) begin
          state_d = ST_BRAKE;
        end else if (dir != dir_sh_q) begin
          state_d  = ST_DEAD;
          dt_cnt_d = dt_sh_q;
        end
      end
      ST_DEAD: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (brk) begin
          state_d = ST_BRAKE;
        end else if (dt_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          dt_cnt_d = dt_cnt_q - DT_ONE;
        end
      end
      default: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (!brk) begin
          state_d  = ST_DEAD;
          dt_cnt_d = dt_sh_q;
        end
      end
    endcase
  end

  // Period counter runs only while staying in RUN with a live period; otherwise it sits at 0.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && period_run && !wrap) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Shadow registers capture the register file at period ends and continuously outside RUN.
  always_comb begin
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    dir_sh_d    = dir_sh_q;
    dt_sh_d     = dt_sh_q;
    if (load_sh) begin
      period_sh_d = slv_reg1[C_CNT_WIDTH-1:0];
      dir_sh_d    = dir;
      dt_sh_d     = slv_reg3[C_DT_WIDTH-1:0];
    end
`ifdef MOTOR_PWM_DUTY_RAMP_EN
    // Duty restarts from zero after every stop or reversal, so each start is soft.
    if ((state_d == ST_IDLE) || (state_d == ST_DEAD)) begin
      duty_sh_d = '0;
    end else if (load_sh) begin
      duty_sh_d = ramp_toward(duty_sh_q, slv_reg2[C_CNT_WIDTH-1:0], slv_reg3[31:16]);
    end
`else
    if (load_sh) begin
      duty_sh_d = slv_reg2[C_CNT_WIDTH-1:0];
    end
`endif
  end

  // Pin mapping: PWM steered by direction in RUN, both high in BRAKE, both low otherwise.
  always_comb begin
    out_a_d = 1'b0;
    out_b_d = 1'b0;
    tick_d  = wrap;
    case (state_q)
      ST_RUN: begin
        out_a_d = pwm & ~dir_sh_q;
        out_b_d = pwm & dir_sh_q;
      end
      ST_BRAKE: begin
        out_a_d = 1'b1;
        out_b_d = 1'b1;
      end
      default: begin
        out_a_d = 1'b0;
        out_b_d = 1'b0;
      end
    endcase
  end

  // State, counters, shadows and registered pins with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dt_cnt_q    <= '0;
      period_sh_q <= '0;
      duty_sh_q   <= '0;
      dir_sh_q    <= 1'b0;
      dt_sh_q     <= '0;
      out_a_q     <= 1'b0;
      out_b_q     <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dt_cnt_q    <= dt_cnt_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      dir_sh_q    <= dir_sh_d;
      dt_sh_q     <= dt_sh_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      tick_q      <= tick_d;
    end
  end

  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign period_tick = tick_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_motor_pwm_core.sv
// tb_motor_pwm_core: directed-vector bench for motor_pwm_core.
// Latency: outputs sampled 1 time unit after each ACLK rising edge.
// Backpressure: none; all waits are fixed cycle counts.
module tb_motor_pwm_core;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic        out_a, out_b, period_tick;
  logic [1:0]  state_o;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  motor_pwm_core dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .slv_reg0    (slv_reg0),
    .slv_reg1    (slv_reg1),
    .slv_reg2    (slv_reg2),
    .slv_reg3    (slv_reg3),
    .out_a       (out_a),
    .out_b       (out_b),
    .period_tick (period_tick),
    .state_o     (state_o)
  );

  task automatic step_clk();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    slv_reg0 = 32'h0; slv_reg1 = 32'h0; slv_reg2 = 32'h0; slv_reg3 = 32'h0;
    step_clk();
    step_clk();
    total++; if (out_a !== 1'b0) begin bad++; $display("FAIL reset_out_a got=%b want=0", out_a); end
    total++; if (out_b !== 1'b0) begin bad++; $display("FAIL reset_out_b got=%b want=0", out_b); end
    total++; if (period_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", period_tick); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_o); end
    ARESET = 1'b0;
    step_clk();
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL idle_hold_state got=%0d want=0", state_o); end
  endtask

  task automatic test_pwm();
    slv_reg1 = 32'd10; slv_reg2 = 32'd3; slv_reg3 = 32'd5;
    step_clk();
    slv_reg0 = 32'h1;
    step_clk();
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL pwm_entry_state got=%0d want=1", state_o); end
    total++; if (out_a !== 1'b0) begin bad++; $display("FAIL pwm_entry_out_a got=%b want=0", out_a); end
    for (int i = 0; i < 20; i++) begin
      step_clk();
      total++; if (out_a !== ((i % 10) < 3)) begin bad++; $display("FAIL pwm_out_a cyc=%0d got=%b want=%b", i, out_a, ((i % 10) < 3)); end
      total++; if (out_b !== 1'b0) begin bad++; $display("FAIL pwm_out_b cyc=%0d got=%b want=0", i, out_b); end
      total++; if (period_tick !== ((i % 10) == 9)) begin bad++; $display("FAIL pwm_tick cyc=%0d got=%b want=%b", i, period_tick, ((i % 10) == 9)); end
    end
  endtask

  task automatic test_duty_update();
    for (int i = 0; i < 10; i++) begin
      step_clk();
      total++; if (out_a !== (i < 3)) begin bad++; $display("FAIL duty_cur_period cyc=%0d got=%b want=%b", i, out_a, (i < 3)); end
      if (i == 3) slv_reg2 = 32'd7;
    end
    for (int i = 0; i < 10; i++) begin
      step_clk();
      total++; if (out_a !== (i < 7)) begin bad++; $display("FAIL duty_next_period cyc=%0d got=%b want=%b", i, out_a, (i < 7)); end
      total++; if (period_tick !== (i == 9)) begin bad++; $display("FAIL duty_next_tick cyc=%0d got=%b want=%b", i, period_tick, (i == 9)); end
    end
  endtask

  task automatic test_direction();
    slv_reg2 = 32'd3;
    slv_reg0 = 32'h3;
    step_clk();
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL dir_dead_state got=%0d want=2", state_o); end
    for (int i = 0; i < 6; i++) begin
      step_clk();
      total++; if ({out_a, out_b} !== 2'b00) begin bad++; $display("FAIL dir_dead_outs cyc=%0d got=%b%b want=00", i, out_a, out_b); end
    end
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL dir_resume_state got=%0d want=1", state_o); end
    for (int i = 0; i < 10; i++) begin
      step_clk();
      total++; if (out_b !== (i < 3)) begin bad++; $display("FAIL dir_out_b cyc=%0d got=%b want=%b", i, out_b, (i < 3)); end
      total++; if (out_a !== 1'b0) begin bad++; $display("FAIL dir_out_a cyc=%0d got=%b want=0", i, out_a); end
      total++; if (period_tick !== (i == 9)) begin bad++; $display("FAIL dir_tick cyc=%0d got=%b want=%b", i, period_tick, (i == 9)); end
    end
  endtask

  task automatic test_brake();
    slv_reg0 = 32'h7;
    step_clk();
    step_clk();
    total++; if ({out_a, out_b} !== 2'b11) begin bad++; $display("FAIL brake_outs got=%b%b want=11", out_a, out_b); end
    total++; if (state_o !== 2'd3) begin bad++; $display("FAIL brake_state got=%0d want=3", state_o); end
    step_clk();
    total++; if ({out_a, out_b} !== 2'b11) begin bad++; $display("FAIL brake_hold got=%b%b want=11", out_a, out_b); end
    slv_reg0 = 32'h1;
    step_clk();
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL brake_release_state got=%0d want=2", state_o); end
    for (int i = 0; i < 6; i++) begin
      step_clk();
      total++; if ({out_a, out_b} !== 2'b00) begin bad++; $display("FAIL brake_dead_outs cyc=%0d got=%b%b want=00", i, out_a, out_b); end
    end
    for (int i = 0; i < 10; i++) begin
      step_clk();
      total++; if (out_a !== (i < 3)) begin bad++; $display("FAIL brake_resume_a cyc=%0d got=%b want=%b", i, out_a, (i < 3)); end
      total++; if (out_b !== 1'b0) begin bad++; $display("FAIL brake_resume_b cyc=%0d got=%b want=0", i, out_b); end
    end
  endtask

  task automatic test_duty_extremes();
    slv_reg2 = 32'd0;
    repeat (10) step_clk();
    for (int i = 0; i < 10; i++) begin
      step_clk();
      total++; if (out_a !== 1'b0) begin bad++; $display("FAIL duty0_out_a cyc=%0d got=%b want=0", i, out_a); end
      total++; if (period_tick !== (i == 9)) begin bad++; $display("FAIL duty0_tick cyc=%0d got=%b want=%b", i, period_tick, (i == 9)); end
    end
    slv_reg2 = 32'd12;
    repeat (10) step_clk();
    for (int i = 0; i < 10; i++) begin
      step_clk();
      total++; if (out_a !== 1'b1) begin bad++; $display("FAIL duty_full_out_a cyc=%0d got=%b want=1", i, out_a); end
      total++; if (period_tick !== (i == 9)) begin bad++; $display("FAIL duty_full_tick cyc=%0d got=%b want=%b", i, period_tick, (i == 9)); end
    end
  endtask

  task automatic test_disable();
    slv_reg0 = 32'h0;
    step_clk();
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL disable_state got=%0d want=0", state_o); end
    total++; if (out_a !== 1'b1) begin bad++; $display("FAIL disable_last_run got=%b want=1", out_a); end
    step_clk();
    total++; if (out_a !== 1'b0) begin bad++; $display("FAIL disable_out_a got=%b want=0", out_a); end
    slv_reg2 = 32'd3;
    slv_reg0 = 32'h1;
    step_clk();
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL reenable_state got=%0d want=1", state_o); end
  endtask

  task automatic test_reset_deadtime();
    slv_reg0 = 32'h3;
    step_clk();
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL rst_dead_entry got=%0d want=2", state_o); end
    step_clk();
    ARESET = 1'b1;
    slv_reg1 = 32'd0;
    slv_reg0 = 32'h1;
    step_clk();
    total++; if ({out_a, out_b} !== 2'b00) begin bad++; $display("FAIL rst_dead_outs got=%b%b want=00", out_a, out_b); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_dead_state got=%0d want=0", state_o); end
    ARESET = 1'b0;
    step_clk();
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL zero_period_state got=%0d want=1", state_o); end
    for (int i = 0; i < 25; i++) begin
      step_clk();
      total++; if ({out_a, out_b} !== 2'b00) begin bad++; $display("FAIL zero_period_outs cyc=%0d got=%b%b want=00", i, out_a, out_b); end
      total++; if (period_tick !== 1'b0) begin bad++; $display("FAIL zero_period_tick cyc=%0d got=%b want=0", i, period_tick); end
    end
    slv_reg0 = 32'h5;
    step_clk();
    step_clk();
    total++; if ({out_a, out_b} !== 2'b11) begin bad++; $display("FAIL rst_brake_pre got=%b%b want=11", out_a, out_b); end
    ARESET = 1'b1;
    step_clk();
    total++; if ({out_a, out_b} !== 2'b00) begin bad++; $display("FAIL rst_brake_outs got=%b%b want=00", out_a, out_b); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_brake_state got=%0d want=0", state_o); end
    slv_reg0 = 32'h0;
    ARESET = 1'b0;
    step_clk();
  endtask

`ifdef MOTOR_PWM_DUTY_RAMP_EN
  task automatic test_ramp();
    int highs;
    int want;
    slv_reg1 = 32'd10; slv_reg2 = 32'd8; slv_reg3 = 32'h0002_0000;
    step_clk();
    slv_reg0 = 32'h1;
    step_clk();
    for (int p = 0; p < 5; p++) begin
      highs = 0;
      for (int i = 0; i < 10; i++) begin
        step_clk();
        if (out_a === 1'b1) highs++;
      end
      want = (p < 4) ? 2 * (p + 1) : 8;
      total++; if (highs !== want) begin bad++; $display("FAIL ramp_period p=%0d got=%0d want=%0d", p, highs, want); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pwm();
    test_duty_update();
    test_direction();
    test_brake();
    test_duty_extremes();
    test_disable();
    test_reset_deadtime();
`ifdef MOTOR_PWM_DUTY_RAMP_EN
    test_ramp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_pwm_core.md
Name: motor_pwm_core

Overview:
- Downstream consumer of the MotorDriver AXI4-Lite register slave (4 × 32-bit registers at offsets 0x0/0x4/0x8/0xC).
- Turns the four register values into registered H-bridge drive signals: edge-aligned PWM, direction select, brake, and dead-time on direction reversal.
- Register values are sampled into shadow registers only at PWM period boundaries, so a period is never truncated or glitched by an AXI write.

Parameters:
- C_CNT_WIDTH, 16, width of the period/duty counter; uses the low bits of the period and duty registers.
- C_DT_WIDTH, 8, width of the dead-time counter; uses the low bits of reg3.

Ports:
- ACLK  in  1  single clock, shared with the AXI slave.
- ARESET  in  1  synchronous, active-high reset.
- slv_reg0  in  32  control: [0] enable, [1] dir, [2] brake.
- slv_reg1  in  32  period in ACLK cycles, bits [C_CNT_WIDTH-1:0].
- slv_reg2  in  32  duty in ACLK cycles, bits [C_CNT_WIDTH-1:0].
- slv_reg3  in  32  [C_DT_WIDTH-1:0] dead-time cycles; [31:16] ramp step (used only with the optional feature).
- out_a  out  1  H-bridge input A.
- out_b  out  1  H-bridge input B.
- period_tick  out  1  1-cycle pulse on the last count of each period.
- state_o  out  2  FSM state: 0 IDLE, 1 RUN, 2 DEADTIME, 3 BRAKE.

Behaviour:
- Reset values:
  - out_a, out_b, period_tick = 0; state_o = IDLE.
  - cnt = 0; dt_cnt = 0.
  - Shadow registers (period_sh, duty_sh, dir_sh, dt_sh) = 0.
- Counter, in RUN only:
  - cnt increments each cycle; wraps to 0 when cnt == period_sh-1.
  - period_tick = 1 on that cycle.
  - Shadows load from the registers on the wrap cycle.
  - In all other states cnt is held at 0 and the shadows load every cycle.
- period_sh == 0: treated as stopped; the PWM level is 0 and period_tick never fires.
- PWM level: pwm = (cnt < duty_sh).
  - duty_sh == 0 gives 0 %.
  - duty_sh >= period_sh gives 100 % (constant 1).
- Output mapping in RUN:
  - dir_sh = 0: out_a = pwm, out_b = 0.
  - dir_sh = 1: out_a = 0, out_b = pwm.
- Outputs are registered: 1 ACLK latency from cnt/state to the pins. out_a and out_b are never both 1 except in BRAKE.
- FSM. Evaluation order each cycle: enable low, then brake, then direction change.
  - IDLE: outputs 0. Go to RUN when enable = 1 and brake = 0, with cnt = 0 and shadows freshly loaded. Go to BRAKE when enable = 1 and brake = 1.
  - RUN:
    - enable = 0: go to IDLE on the next cycle, immediately (no wait for period end).
    - brake = 1: go to BRAKE immediately.
    - slv_reg0[1] != dir_sh: go to DEADTIME and load dt_cnt = dt_sh.
  - DEADTIME:
    - Outputs 0; dt_cnt decrements each cycle.
    - At dt_cnt == 0: go to RUN with dir_sh = new dir and cnt = 0.
    - dt_sh == 0 gives exactly 1 cycle in DEADTIME.
    - enable low or brake overrides the countdown.
  - BRAKE: out_a = out_b = 1.
    - brake cleared and enable = 1: go to DEADTIME, then RUN.
    - enable = 0: go to IDLE.
- Register writes during RUN affect only the next period. Exception: dir/brake/enable, which act in the next cycle as described above.
- ARESET asserted mid-period: on the next edge, all outputs are 0 and the FSM is in IDLE, regardless of state.

Optional Feature:
- Macro: MOTOR_PWM_DUTY_RAMP_EN.
- Defined: at each shadow load, duty_sh moves toward slv_reg2 by at most slv_reg3[31:16] counts, saturating at the target.
  - Ramp step 0 means a direct load.
  - Entering DEADTIME or IDLE resets duty_sh to 0, so every direction reversal soft-starts.
- Undefined: duty_sh loads slv_reg2 directly; slv_reg3[31:16] is ignored.

Test Plan:
- reg1 = 10, reg2 = 3, reg0 = 0x1 → out_a high 3 of every 10 cycles, out_b = 0; period_tick every 10 cycles; first out_a rise 1 cycle after RUN entry.
- In RUN, write reg2 = 7 mid-period (cnt = 4) → current period keeps 3 high cycles; the next period has 7 high cycles.
- reg3 = 5, toggle reg0 to 0x3 while running → out_a drops; both outputs 0 for 6 cycles; then out_b pulses at 3/10 starting from cnt = 0.
- reg0 = 0x5 (brake) → out_a = out_b = 1 within 2 cycles; clear to 0x1 → dead-time, then PWM resumes. Also reg2 = 0 gives a constant 0, and reg2 = 12 with reg1 = 10 gives a constant 1.
- Assert ARESET for 1 cycle while in DEADTIME → outputs 0, state_o = 0; then reg1 = 0 with enable → no pulses, no period_tick.
- With MOTOR_PWM_DUTY_RAMP_EN, reg2 = 8, reg3 = 0x0002_0000, reg1 = 10 → high counts per period 2, 4, 6, 8, 8.
